// File: rtl/dac_soft_ramp_output.sv
// Soft-start/soft-stop gain ramp for the two-channel mixer stream, followed by
// 14-bit saturation, offset-binary conversion and a sticky clip-event counter.
module dac_soft_ramp_output #(
    parameter int ADC_WIDTH        = 14,
    parameter int AXIS_DATA_WIDTH  = 16,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int RAMP_Q           = 16,
    parameter int SAT_CNT_WIDTH    = 16
) (
    input  logic                        adc_clk,
    input  logic                        adc_rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    input  logic                        out_enable,
    input  logic [RAMP_Q-1:0]           ramp_step,
    input  logic                        sat_clear,
    output logic [ADC_WIDTH-1:0]        dac_dat_a,
    output logic [ADC_WIDTH-1:0]        dac_dat_b,
    output logic                        dac_valid,
    output logic [1:0]                  ramp_state,
    output logic [SAT_CNT_WIDTH-1:0]    sat_count
);

    localparam int GW = RAMP_Q + 1;
    localparam int PW = AXIS_DATA_WIDTH + RAMP_Q + 2;
    localparam logic [GW-1:0]            UNITY     = {1'b1, {RAMP_Q{1'b0}}};
    localparam logic [GW-1:0]            GAIN_ZERO = {GW{1'b0}};
    localparam logic [RAMP_Q-1:0]        STEP_ZERO = {RAMP_Q{1'b0}};
    localparam logic [ADC_WIDTH-1:0]     MIDSCALE  = {1'b1, {(ADC_WIDTH-1){1'b0}}};
    localparam logic [SAT_CNT_WIDTH-1:0] SAT_FULL  = {SAT_CNT_WIDTH{1'b1}};
    localparam logic [SAT_CNT_WIDTH-1:0] SAT_ONE   = {{(SAT_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0]     SAT_MAX   = PW'((64'sd1 <<< (ADC_WIDTH-1)) - 64'sd1);
    localparam logic signed [PW-1:0]     SAT_MIN   = PW'(-(64'sd1 <<< (ADC_WIDTH-1)));

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } ramp_state_t;

    // Rescale a Q-format product, clamp to the DAC range and return {clip, offset-binary code}.
    function automatic logic [ADC_WIDTH:0] sat_offset(input logic signed [PW-1:0] prod);
        logic signed [PW-1:0]  shifted;
        logic [ADC_WIDTH-1:0]  code;
        logic                  clip;
        shifted = prod >>> RAMP_Q;
        if (shifted > SAT_MAX) begin
            code = {1'b0, {(ADC_WIDTH-1){1'b1}}};
            clip = 1'b1;
        end else if (shifted < SAT_MIN) begin
            code = {1'b1, {(ADC_WIDTH-1){1'b0}}};
            clip = 1'b1;
        end else begin
            code = shifted[ADC_WIDTH-1:0];
            clip = 1'b0;
        end
        return {clip, ~code[ADC_WIDTH-1], code[ADC_WIDTH-2:0]};
    endfunction

    ramp_state_t              state_r, state_nxt_s;
    logic [GW-1:0]            gain_r, gain_nxt_s, gain_up_s, gain_dn_s;
    logic [GW:0]              gain_sum_s;
    logic signed [PW-1:0]     x_a_ext_s, x_b_ext_s, gain_ext_s;
    logic signed [PW-1:0]     prod_a_r, prod_b_r;
    logic                     valid1_r;
    logic [ADC_WIDTH:0]       res_a_s, res_b_s;
    logic [ADC_WIDTH-1:0]     dac_a_r, dac_b_r;
    logic                     dac_valid_r;
    logic [SAT_CNT_WIDTH-1:0] sat_r;

    assign gain_sum_s = {1'b0, gain_r} + {2'b00, ramp_step};
    assign x_a_ext_s  = {{(PW-AXIS_DATA_WIDTH){S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}},
                         S_AXIS_tdata[AXIS_TDATA_WIDTH-1 -: AXIS_DATA_WIDTH]};
    assign x_b_ext_s  = {{(PW-AXIS_DATA_WIDTH){S_AXIS_tdata[AXIS_DATA_WIDTH-1]}},
                         S_AXIS_tdata[AXIS_DATA_WIDTH-1:0]};
    assign gain_ext_s = {{(PW-GW){1'b0}}, gain_r};
    assign res_a_s    = sat_offset(prod_a_r);
    assign res_b_s    = sat_offset(prod_b_r);

    // Clamped ramp targets; a zero step means jump straight to the end point.
    always_comb begin
        gain_up_s = UNITY;
        gain_dn_s = GAIN_ZERO;
        if (ramp_step == STEP_ZERO || gain_sum_s >= {1'b0, UNITY}) begin
            gain_up_s = UNITY;
        end else begin
            gain_up_s = gain_sum_s[GW-1:0];
        end
        if (ramp_step == STEP_ZERO || {1'b0, ramp_step} >= gain_r) begin
            gain_dn_s = GAIN_ZERO;
        end else begin
            gain_dn_s = gain_r - {1'b0, ramp_step};
        end
    end

    // Ramp FSM next state; a direction change holds g for that sample.
    always_comb begin
        state_nxt_s = state_r;
        gain_nxt_s  = gain_r;
        if (S_AXIS_tvalid) begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = out_enable ? ST_RAMP_UP : ST_IDLE;
                end
                ST_RAMP_UP: begin
                    if (!out_enable) begin
                        state_nxt_s = ST_RAMP_DOWN;
                    end else begin
                        gain_nxt_s  = gain_up_s;
                        state_nxt_s = (gain_up_s == UNITY) ? ST_RUN : ST_RAMP_UP;
                    end
                end
                ST_RUN: begin
                    gain_nxt_s  = UNITY;
                    state_nxt_s = out_enable ? ST_RUN : ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (out_enable) begin
                        state_nxt_s = ST_RAMP_UP;
                    end else begin
                        gain_nxt_s  = gain_dn_s;
                        state_nxt_s = (gain_dn_s == GAIN_ZERO) ? ST_IDLE : ST_RAMP_DOWN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    gain_nxt_s  = GAIN_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            gain_nxt_s  = gain_r;
        end
    end

    // FSM and gain registers.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_r <= ST_IDLE;
            gain_r  <= GAIN_ZERO;
        end else begin
            state_r <= state_nxt_s;
            gain_r  <= gain_nxt_s;
        end
    end

    // Stage 1: multiply by the pre-update gain.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            prod_a_r <= {PW{1'b0}};
            prod_b_r <= {PW{1'b0}};
            valid1_r <= 1'b0;
        end else begin
            if (S_AXIS_tvalid) begin
                prod_a_r <= x_a_ext_s * gain_ext_s;
                prod_b_r <= x_b_ext_s * gain_ext_s;
            end else begin
                prod_a_r <= prod_a_r;
                prod_b_r <= prod_b_r;
            end
            valid1_r <= S_AXIS_tvalid;
        end
    end

    // Stage 2: saturated offset-binary outputs, held across gaps.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            dac_a_r     <= MIDSCALE;
            dac_b_r     <= MIDSCALE;
            dac_valid_r <= 1'b0;
        end else begin
            if (valid1_r) begin
                dac_a_r <= res_a_s[ADC_WIDTH-1:0];
                dac_b_r <= res_b_s[ADC_WIDTH-1:0];
            end else begin
                dac_a_r <= dac_a_r;
                dac_b_r <= dac_b_r;
            end
            dac_valid_r <= valid1_r;
        end
    end

    // Sticky clip counter; clear wins over a coincident clip.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            sat_r <= {SAT_CNT_WIDTH{1'b0}};
        end else if (sat_clear) begin
            sat_r <= {SAT_CNT_WIDTH{1'b0}};
        end else if (valid1_r && (res_a_s[ADC_WIDTH] || res_b_s[ADC_WIDTH]) && sat_r != SAT_FULL) begin
            sat_r <= sat_r + SAT_ONE;
        end else begin
            sat_r <= sat_r;
        end
    end

    assign dac_dat_a  = dac_a_r;
    assign dac_dat_b  = dac_b_r;
    assign dac_valid  = dac_valid_r;
    assign ramp_state = state_r;
    assign sat_count  = sat_r;

endmodule

// File: tb/tb_dac_soft_ramp_output.sv
// Scoreboard bench for dac_soft_ramp_output: a behavioural gain/FSM model queues
// expected DAC codes at drive time and they are compared as dac_valid appears.
module tb_dac_soft_ramp_output;

    logic        adc_clk = 1'b0;
    logic        adc_rst;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic        out_enable;
    logic [15:0] ramp_step;
    logic        sat_clear;
    logic [13:0] dac_dat_a, dac_dat_b;
    logic        dac_valid;
    logic [1:0]  ramp_state;
    logic [15:0] sat_count;

    dac_soft_ramp_output dut (
        .adc_clk(adc_clk), .adc_rst(adc_rst),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
        .out_enable(out_enable), .ramp_step(ramp_step), .sat_clear(sat_clear),
        .dac_dat_a(dac_dat_a), .dac_dat_b(dac_dat_b), .dac_valid(dac_valid),
        .ramp_state(ramp_state), .sat_count(sat_count)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        int a;
        int b;
        bit clip;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // model state
    int   g_m, st_m, sat_m, last_a, last_b;
    bit   hist0, hist1, s1_clip;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void calc(input logic [15:0] x, input int g, output int code, output bit clip);
        longint p;
        longint sh;
        p  = longint'($signed(x)) * longint'(g);
        sh = p >>> 16;
        clip = 1'b0;
        if (sh > 8191) begin
            sh = 8191;
            clip = 1'b1;
        end else if (sh < -8192) begin
            sh = -8192;
            clip = 1'b1;
        end
        code = int'(sh) + 8192;
    endfunction

    task automatic model_reset();
        g_m = 0; st_m = 0; sat_m = 0;
        last_a = 32'h2000; last_b = 32'h2000;
        hist0 = 1'b0; hist1 = 1'b0; s1_clip = 1'b0;
        sb.delete();
    endtask

    task automatic cyc(input bit rst, input bit v, input logic [15:0] xa, input logic [15:0] xb,
                       input bit en, input logic [15:0] stp, input bit clr);
        exp_t e;
        int   ca, cb;
        bit   kla, klb;
        @(negedge adc_clk);
        check_val("dac_valid", {31'd0, dac_valid}, {31'd0, hist1});
        if (hist1) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                last_a = e.a;
                last_b = e.b;
            end
        end
        check_val("dac_dat_a", {18'd0, dac_dat_a}, last_a);
        check_val("dac_dat_b", {18'd0, dac_dat_b}, last_b);
        check_val("ramp_state", {30'd0, ramp_state}, st_m);
        check_val("sat_count", {16'd0, sat_count}, sat_m);

        adc_rst = rst; S_AXIS_tvalid = v; S_AXIS_tdata = {xa, xb};
        out_enable = en; ramp_step = stp; sat_clear = clr;

        if (rst) begin
            model_reset();
        end else begin
            if (clr) sat_m = 0;
            else if (hist0 && s1_clip && sat_m != 65535) sat_m = sat_m + 1;
            s1_clip = 1'b0;
            if (v) begin
                calc(xa, g_m, ca, kla);
                calc(xb, g_m, cb, klb);
                e.a = ca; e.b = cb; e.clip = kla | klb;
                s1_clip = e.clip;
                sb.push_back(e);
                case (st_m)
                    0: if (en) st_m = 1;
                    1: if (!en) st_m = 3;
                       else begin
                           g_m = (stp == 16'd0) ? 65536 : g_m + int'(stp);
                           if (g_m >= 65536) begin g_m = 65536; st_m = 2; end
                       end
                    2: if (!en) st_m = 3;
                    default: if (en) st_m = 1;
                       else begin
                           g_m = (stp == 16'd0) ? 0 : g_m - int'(stp);
                           if (g_m <= 0) begin g_m = 0; st_m = 0; end
                       end
                endcase
            end
            hist1 = hist0;
            hist0 = v;
        end
    endtask

    initial begin
        adc_rst = 1'b1; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = 32'd0;
        out_enable = 1'b0; ramp_step = 16'd0; sat_clear = 1'b0;
        model_reset();
        repeat (3) @(posedge adc_clk);

        // reset, then idle stream with a gap: always midscale
        cyc(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0, 16'h4000, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, i != 3, 16'($urandom), 16'($urandom), 1'b0, 16'h4000, 1'b0);

        // quarter-step ramp up to RUN
        for (int i = 0; i < 7; i++)
            cyc(1'b0, 1'b1, 16'h1000, 16'hF000, 1'b1, 16'h4000, 1'b0);

        // full-scale clipping, clear coincident with a clip
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 16'h4000, 1'b0);
        cyc(1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 16'h4000, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 16'h7FFF, 16'h0100, 1'b1, 16'h4000, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 16'h0F00, 16'hE100, 1'b1, 16'h4000, 1'b0);

        // ramp down to idle, then reverse mid ramp-up at g = 0.5
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, 16'h1000, 16'hF000, 1'b0, 16'h4000, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 16'h1000, 16'hF000, 1'b1, 16'h4000, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 16'h1000, 16'hF000, 1'b0, 16'h4000, 1'b0);

        // zero step: one sample in each ramp state
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 16'h1F00, 16'hC000, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 16'h1F00, 16'hC000, 1'b0, 16'h0000, 1'b0);

        // gaps during a ramp, then reset mid-ramp
        for (int i = 0; i < 12; i++)
            cyc(1'b0, (i % 3) != 1, 16'($urandom), 16'($urandom), 1'b1, 16'h2000, 1'b0);
        cyc(1'b1, 1'b1, 16'h1000, 16'h1000, 1'b1, 16'h2000, 1'b0);
        for (int i = 0; i < 6; i++)
            cyc(1'b0, i != 2, 16'($urandom), 16'($urandom), 1'b0, 16'h2000, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h2000, 1'b0);

        check_val("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_soft_ramp_output.md
Name: dac_soft_ramp_output

Overview:
- Downstream consumer of the volume/Q-control mixer's 32-bit output stream: two signed 16-bit channels. The upper half carries the volume-adjusted 14-bit signal, sign-extended.
- Applies a soft-start/soft-stop gain ramp to both channels, then saturates each to 14 bits and converts to offset binary for the DAC pins.
- Keeps a saturation-event counter for host readback.
- Runs in the adc_clk domain, between the mixer and the DAC output registers.

Parameters:
- ADC_WIDTH, 14, DAC sample width in bits.
- AXIS_DATA_WIDTH, 16, per-channel width inside tdata.
- AXIS_TDATA_WIDTH, 32, input stream width (two channels).
- RAMP_Q, 16, gain fraction bits; unity gain = 2^RAMP_Q.
- SAT_CNT_WIDTH, 16, saturation counter width.

Ports:
- adc_clk  in  1  single clock for all logic.
- adc_rst  in  1  reset; synchronous, active-high.
- S_AXIS_tdata  in  32  [31:16] ch A signed, [15:0] ch B signed.
- S_AXIS_tvalid  in  1  sample valid; there is no tready and the block never stalls.
- out_enable  in  1  level: 1 = ramp to unity and run, 0 = ramp to zero and idle.
- ramp_step  in  16  gain increment per valid sample, unsigned; 0 = step gain instantly.
- sat_clear  in  1  synchronous clear of sat_count.
- dac_dat_a  out  14  ch A, offset binary.
- dac_dat_b  out  14  ch B, offset binary.
- dac_valid  out  1  output sample valid.
- ramp_state  out  2  0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN.
- sat_count  out  SAT_CNT_WIDTH  count of saturated output samples.

Behaviour:
- Reset values: dac_dat_a = dac_dat_b = 14'h2000 (midscale); dac_valid = 0; ramp_state = IDLE; gain g = 0; sat_count = 0. Reset asserted mid-ramp aborts immediately to these values.
- Gain register g is RAMP_Q+1 bits wide, unsigned, range 0..2^RAMP_Q. It updates only on cycles with S_AXIS_tvalid = 1.
- The sample captured on a given valid cycle uses g as it was before that cycle's update.
- State machine transitions, evaluated on valid cycles only:
  - IDLE: out_enable = 1 -> RAMP_UP.
  - RAMP_UP: g <= min(g + ramp_step, 2^RAMP_Q). When g reaches 2^RAMP_Q -> RUN. out_enable = 0 -> RAMP_DOWN, starting from the current g.
  - RUN: g held at 2^RAMP_Q. out_enable = 0 -> RAMP_DOWN.
  - RAMP_DOWN: g <= max(g - ramp_step, 0). When g reaches 0 -> IDLE. out_enable = 1 -> RAMP_UP, starting from the current g.
  - ramp_step = 0: g jumps to its target in one valid cycle; the state passes through RAMP_UP/RAMP_DOWN for exactly one valid sample.
- Datapath, 2-cycle latency from the valid input cycle to dac_valid:
  - Stage 1: pA = xA * g, where xA is signed 16-bit and g is zero-extended, giving a signed 34-bit product. Same for pB.
  - Stage 2: arithmetic shift right by RAMP_Q, saturate to [-8192, 8191], convert to offset binary by inverting the MSB.
- dac_valid is S_AXIS_tvalid delayed by 2 cycles. On invalid cycles, dac_dat_* hold their last value.
- In IDLE, g = 0, so outputs are midscale (14'h2000).
- Saturation counter:
  - Increments by 1 per output sample in which either channel clipped, counting once even if both clipped.
  - Sticks at all-ones; it does not wrap.
  - sat_clear takes priority over a simultaneous increment.

Test Plan:
- Reset, then a valid stream with out_enable = 0 -> dac_dat_a/b = 14'h2000 throughout, dac_valid follows tvalid 2 cycles later, ramp_state = 0.
- ch A = 16'h1000 (4096), ramp_step = 16'h4000, out_enable 0->1 -> g steps 0, 0.25, 0.5, 0.75, 1.0. Output A codes are 0x2000, 0x2400, 0x2800, 0x2C00, then 0x3000 once in RUN.
- RUN with ch A = 16'h7FFF, ch B = 16'h8000 -> A = 14'h3FFF, B = 14'h0000; sat_count increments by 1 per sample. sat_clear asserted in the same cycle as a clip leaves sat_count = 0.
- RAMP_UP at g = 0.5, drop out_enable -> next state RAMP_DOWN, g falls 0.25, 0, then IDLE; no jump to unity occurs.
- ramp_step = 0, toggle out_enable 0->1->0 -> one RAMP_UP sample, then RUN at full gain; one RAMP_DOWN sample, then IDLE at midscale.
- Gaps in S_AXIS_tvalid during a ramp -> g and state frozen, outputs held, dac_valid low 2 cycles after each gap; assert adc_rst mid-ramp -> all reset values on the next cycle.
